// File: rtl/rfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module  : rfile_sb_if
// Brief   : Decode/writeback-facing bus of the rfile_sb register file.
// Revision: 1.0 - initial release
// ============================================================================
interface rfile_sb_if #(
    parameter int dataWidth    = 32,
    parameter int AddressWidth = 5,
    parameter int NUM_READ     = 2
);
    logic                             RFwrite;
    logic [AddressWidth-1:0]          RegW;
    logic [dataWidth-1:0]             dataW;
    logic [NUM_READ*AddressWidth-1:0] RegR;
    logic [NUM_READ*dataWidth-1:0]    dataR;
    logic [NUM_READ-1:0]              busyR;
    logic                             busy_set;
    logic [AddressWidth-1:0]          busy_reg;
    logic                             clr_req;
    logic                             clr_busy;

    modport master (
        output RFwrite, RegW, dataW, RegR, busy_set, busy_reg, clr_req,
        input  dataR, busyR, clr_busy
    );

    modport slave (
        input  RFwrite, RegW, dataW, RegR, busy_set, busy_reg, clr_req,
        output dataR, busyR, clr_busy
    );
endinterface
`default_nettype wire

// File: rtl/rfile_sb.sv
`default_nettype none
// ============================================================================
// Module  : rfile_sb
// Brief   : RISC-V integer register file with pending-write scoreboard and
//           sequential bulk-clear engine. Optional macro RFILE_BYPASS_EN
//           forwards same-cycle write data to the read ports.
// Revision: 1.0 - initial release
// ============================================================================
module rfile_sb #(
    parameter int dataWidth    = 32,
    parameter int AddressWidth = 5,
    parameter int NUM_READ     = 2
) (
    input  logic       Clk,
    input  logic       reset,
    rfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << AddressWidth;
    localparam logic [AddressWidth-1:0] PTR_ONE = AddressWidth'(1);
    localparam logic [AddressWidth-1:0] PTR_TOP = '1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [dataWidth-1:0]    regs [DEPTH];
    logic [DEPTH-1:0]        sb;
    logic [0:0]              state;
    logic [AddressWidth-1:0] ptr;

    logic idle;
    logic wr_accept;
    logic set_accept;

    assign idle       = (state == S_IDLE);
    assign wr_accept  = idle && bus.RFwrite  && (bus.RegW     != '0);
    assign set_accept = idle && bus.busy_set && (bus.busy_reg != '0);
    assign bus.clr_busy = (state == S_SWEEP);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
            sb    <= '0;
            state <= S_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_accept) begin
                        regs[bus.RegW] <= bus.dataW;
                    end
                    if (bus.clr_req) begin
                        sb    <= '0;
                        ptr   <= PTR_ONE;
                        state <= S_SWEEP;
                    end else begin
                        // Set is applied last so a newly issued producer wins.
                        if (wr_accept) begin
                            sb[bus.RegW] <= 1'b0;
                        end
                        if (set_accept) begin
                            sb[bus.busy_reg] <= 1'b1;
                        end
                    end
                end
                S_SWEEP: begin
                    regs[ptr] <= '0;
                    if (ptr == PTR_TOP) begin
                        state <= S_IDLE;
                    end else begin
                        ptr <= ptr + PTR_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [AddressWidth-1:0] idx;
        logic                    hit;

        assign idx = bus.RegR[i*AddressWidth +: AddressWidth];
`ifdef RFILE_BYPASS_EN
        assign hit = wr_accept && (idx == bus.RegW);
`else
        assign hit = 1'b0;
`endif
        assign bus.dataR[i*dataWidth +: dataWidth] =
            (idx == '0) ? '0 : (hit ? bus.dataW : regs[idx]);
        assign bus.busyR[i] =
            (idx == '0) ? 1'b0 :
            (hit ? (set_accept && (bus.busy_reg == idx)) : sb[idx]);
    end
endmodule
`default_nettype wire
